clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Runtime controller for the integer clock divider: accepts a new division ratio from the register file over a valid/ready handshake and applies it glitch-free. It sits directly upstream of the divider and drives its ratio, enable and restart inputs. It samples the divider's output to find a safe switch point. Ratios 0 and 1 are mapped to bypass mode for the downstream clock mux.

## Interface
- W, 4, ratio width (matches divider Width)
- DEFAULT_RATIO, 2, ratio driven out of reset (must be ≥ 2)
- TIMEOUT, 2**(W+1), cycles allowed in WAIT_FALL before a forced switch

- Ref_CLK  in  1  single clock; divider is clocked by the same clock
- RST  in  1  asynchronous, active-high reset
- cfg_ratio  in  W  requested ratio
- cfg_valid  in  1  request strobe
- cfg_ready  out  1  high only in IDLE; transfer on cfg_valid & cfg_ready
- div_clk_in  in  1  divider output, Ref_CLK-synchronous (registered in divider)
- div_ratio  out  W  ratio to divider; reset DEFAULT_RATIO
- div_en  out  1  divider enable; reset 1
- div_rst_n  out  1  one-cycle synchronous restart of divider (active-low); reset 1
- bypass  out  1  1 = downstream mux selects Ref_CLK; reset 0
- busy  out  1  state != IDLE; reset 0
- timeout_err  out  1  sticky; reset 0; cleared on next accepted request

## Operation
- States: IDLE, WAIT_FALL, RESTART, SETTLE. Reset → IDLE.
- Accept in IDLE: latch pend_ratio = cfg_ratio, pend_byp = (cfg_ratio < 2); clear timeout_err.
- No-op: pend_ratio == div_ratio and pend_byp == bypass → remain IDLE, no output change.
- Otherwise: if div_en == 1 → WAIT_FALL, clear timeout counter; if div_en == 0 (bypass active) → RESTART directly.
- Fall detect: prev register samples div_clk_in every cycle (reset 0); fall = prev & ~div_clk_in.
- WAIT_FALL: on fall → RESTART. Counter (W+1 bits) increments each cycle; on reaching TIMEOUT-1 without fall → set timeout_err, → RESTART.
- RESTART (1 cycle, registered outputs): div_rst_n = 0, div_ratio = pend_ratio, bypass = pend_byp, div_en = ~pend_byp. → SETTLE.
- SETTLE (1 cycle): div_rst_n = 1. → IDLE.
- Restart forces the divider's count = 0 and output low while it is already low. No runt high pulse; the low phase stretches by at most 3 cycles.
- pend_ratio 0 or 1: div_ratio still updated; divider held disabled.

## Timing
- Request accepted at edge N. From IDLE with divider disabled: div_rst_n low during cycle N+1, outputs new at N+1, cfg_ready high again at N+3.
- With divider running: RESTART begins on the edge after fall is seen. Worst case N+2+TIMEOUT.
- cfg_valid held while busy: ignored, no queuing; cfg_ready = 0.
- cfg_valid in the same cycle that SETTLE → IDLE: not accepted (cfg_ready registered-state decode).
- div_clk_in stuck high or low: timeout path is the only exit.
- RST mid-operation: immediate return to IDLE and reset values; pending request discarded.
- All outputs registered; no combinational path from cfg_* or div_clk_in to outputs.

## Structure
- Shared package clk_ctrl_pkg: state enum, BYPASS_LIMIT = 2 constant, TIMEOUT default function of W.
- Sub-module clk_fall_det: prev register plus fall pulse; reusable for other clock-domain monitors.
- Top holds FSM, pending registers, timeout counter.

## Test plan
- Reset, W=4: div_ratio=2, div_en=1, bypass=0, div_rst_n=1, cfg_ready=1, busy=0.
- Divider running ratio 2; request 6 while div_clk_in high → no output change until fall, then div_rst_n low one cycle, div_ratio=6, cfg_ready high 2 cycles later. Check no high pulse shorter than 1 cycle.
- Request 1 → bypass=1, div_en=0 after restart. Then request 5 → RESTART on the cycle after acceptance (no WAIT_FALL), bypass=0, div_en=1.
- Request 2 while ratio already 2 → cfg_ready stays high, busy never asserts, no div_rst_n pulse.
- div_clk_in forced high; request 8 → forced switch exactly 32 cycles after entering WAIT_FALL. timeout_err=1, cleared on next accepted request.
- Assert RST during WAIT_FALL → all outputs return to reset values. A request arriving right after deassert is accepted normally.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clock divider runtime controller.
// Ratios below BYPASS_LIMIT cannot be divided and are routed around the divider.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FALL,
        RESTART,
        SETTLE
    } ctrl_state_t;

    localparam int BYPASS_LIMIT = 2;

    function automatic int default_timeout(input int w);
        return 2 ** (w + 1);
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio request bus between the register file (master) and the divider controller (slave).
interface clk_div_ctrl_if #(
    parameter int W = 4
) ();

    logic [W-1:0] cfg_ratio;
    logic         cfg_valid;
    logic         cfg_ready;

    modport master (
        output cfg_ratio,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_ratio,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/clk_fall_det.sv
// Falling-edge detector for a signal that is already synchronous to Ref_CLK.
// The fall pulse is valid for the cycle in which the signal is first seen low.
module clk_fall_det (
    input  logic Ref_CLK,
    input  logic RST,
    input  logic sig,
    output logic fall
);

    logic prev;

    always_ff @(posedge Ref_CLK or posedge RST) begin
        if (RST) begin
            prev <= 1'b0;
        end else begin
            prev <= sig;
        end
    end

    assign fall = prev & ~sig;

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime ratio controller: takes a new ratio over valid/ready and applies it to the
// divider only while the divider output is low, so no runt high pulse can escape.
module clk_div_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int W             = 4,
    parameter int DEFAULT_RATIO = 2,
    parameter int TIMEOUT       = default_timeout(W)
) (
    input  logic           Ref_CLK,
    input  logic           RST,
    clk_div_ctrl_if.slave  cfg,
    input  logic           div_clk_in,
    output logic [W-1:0]   div_ratio,
    output logic           div_en,
    output logic           div_rst_n,
    output logic           bypass,
    output logic           busy,
    output logic           timeout_err
);

    localparam logic [W-1:0] RATIO_RST = W'(DEFAULT_RATIO);
    localparam logic [W-1:0] BYP_LIM   = W'(BYPASS_LIMIT);
    localparam logic [W:0]   CNT_LAST  = (W + 1)'(TIMEOUT - 1);

    ctrl_state_t  state;
    logic [W-1:0] pend_ratio;
    logic         pend_byp;
    logic [W:0]   tmo_cnt;
    logic         fall;
    logic         req_byp;
    logic         accept;

    clk_fall_det u_fall_det (
        .Ref_CLK (Ref_CLK),
        .RST     (RST),
        .sig     (div_clk_in),
        .fall    (fall)
    );

    // Handshake status is a pure decode of the state register, so cfg_* never
    // reaches an output combinationally.
    assign cfg.cfg_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = cfg.cfg_valid && (state == IDLE);
    assign req_byp       = (cfg.cfg_ratio < BYP_LIM);

    always_ff @(posedge Ref_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            pend_ratio  <= RATIO_RST;
            pend_byp    <= 1'b0;
            tmo_cnt     <= '0;
            div_ratio   <= RATIO_RST;
            div_en      <= 1'b1;
            div_rst_n   <= 1'b1;
            bypass      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pend_ratio  <= cfg.cfg_ratio;
                        pend_byp    <= req_byp;
                        timeout_err <= 1'b0;
                        tmo_cnt     <= '0;
                        if (cfg.cfg_ratio == div_ratio && req_byp == bypass) begin
                            state <= IDLE;
                        end else if (div_en) begin
                            state <= WAIT_FALL;
                        end else begin
                            // Divider is stopped, so there is no edge to wait for.
                            state     <= RESTART;
                            div_rst_n <= 1'b0;
                            div_ratio <= cfg.cfg_ratio;
                            bypass    <= req_byp;
                            div_en    <= ~req_byp;
                        end
                    end
                end

                WAIT_FALL: begin
                    if (fall || tmo_cnt == CNT_LAST) begin
                        if (!fall) begin
                            timeout_err <= 1'b1;
                        end
                        state     <= RESTART;
                        div_rst_n <= 1'b0;
                        div_ratio <= pend_ratio;
                        bypass    <= pend_byp;
                        div_en    <= ~pend_byp;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESTART: begin
                    div_rst_n <= 1'b1;
                    state     <= SETTLE;
                end

                SETTLE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: div_clk_in is driven by hand so fall timing is exact,
// and every restart the DUT performs is matched against a queue of expected ratio loads.
module tb_clk_div_ctrl;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] ratio;
        logic         byp;
        logic         en;
    } exp_t;

    logic         Ref_CLK = 1'b0;
    logic         RST;
    logic         div_clk_in;
    logic [W-1:0] div_ratio;
    logic         div_en;
    logic         div_rst_n;
    logic         bypass;
    logic         busy;
    logic         timeout_err;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t sb_item;

    clk_div_ctrl_if #(.W(W)) cfg_bus ();

    clk_div_ctrl #(
        .W             (W),
        .DEFAULT_RATIO (2),
        .TIMEOUT       (32)
    ) dut (
        .Ref_CLK     (Ref_CLK),
        .RST         (RST),
        .cfg         (cfg_bus),
        .div_clk_in  (div_clk_in),
        .div_ratio   (div_ratio),
        .div_en      (div_en),
        .div_rst_n   (div_rst_n),
        .bypass      (bypass),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 Ref_CLK = ~Ref_CLK;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_request(input logic [W-1:0] r);
        @(negedge Ref_CLK);
        check_output("ready_before_req", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        cfg_bus.cfg_ratio = r;
        cfg_bus.cfg_valid = 1'b1;
        @(negedge Ref_CLK);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (cfg_bus.cfg_ready !== 1'b1 && k < 64) begin
            @(negedge Ref_CLK);
            k++;
        end
        check_output(tag, {31'd0, cfg_bus.cfg_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ratio"},   {28'd0, div_ratio},         32'd2);
        check_output({tag, "_en"},      {31'd0, div_en},            32'd1);
        check_output({tag, "_bypass"},  {31'd0, bypass},            32'd0);
        check_output({tag, "_rst_n"},   {31'd0, div_rst_n},         32'd1);
        check_output({tag, "_ready"},   {31'd0, cfg_bus.cfg_ready}, 32'd1);
        check_output({tag, "_busy"},    {31'd0, busy},              32'd0);
        check_output({tag, "_tmo_err"}, {31'd0, timeout_err},       32'd0);
    endtask

    // Every divider restart must correspond to a request the bench expected to take effect.
    always @(negedge Ref_CLK) begin
        if (RST === 1'b0 && div_rst_n === 1'b0) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("[TB] FAIL sb_unexpected_restart: observed div_rst_n=0 expected=1");
            end
            if (exp_q.size() != 0) begin
                sb_item = exp_q.pop_front();
                check_output("sb_ratio",  {28'd0, div_ratio}, {28'd0, sb_item.ratio});
                check_output("sb_bypass", {31'd0, bypass},    {31'd0, sb_item.byp});
                check_output("sb_en",     {31'd0, div_en},    {31'd0, sb_item.en});
            end
        end
    end

    initial begin
        int k;
        RST               = 1'b1;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ratio = '0;
        div_clk_in        = 1'b0;
        repeat (2) @(negedge Ref_CLK);
        check_reset_values("reset");
        RST = 1'b0;

        $display("[TB] no-op request for current ratio 2");
        apply_request(4'd2);
        check_output("noop_busy",  {31'd0, busy},              32'd0);
        check_output("noop_ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        @(negedge Ref_CLK);
        check_output("noop_rst_n", {31'd0, div_rst_n},         32'd1);

        $display("[TB] ratio 6 while divider output high");
        @(negedge Ref_CLK);
        div_clk_in = 1'b1;
        exp_q.push_back('{ratio: 4'd6, byp: 1'b0, en: 1'b1});
        apply_request(4'd6);
        check_output("wf_busy",  {31'd0, busy},              32'd1);
        check_output("wf_ready", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        check_output("wf_ratio", {28'd0, div_ratio},         32'd2);
        repeat (3) @(negedge Ref_CLK);
        check_output("wf_hold_ratio", {28'd0, div_ratio}, 32'd2);
        check_output("wf_hold_rst_n", {31'd0, div_rst_n}, 32'd1);
        div_clk_in = 1'b0;
        @(negedge Ref_CLK);
        check_output("fall_rst_n", {31'd0, div_rst_n}, 32'd0);
        check_output("fall_ratio", {28'd0, div_ratio}, 32'd6);
        @(negedge Ref_CLK);
        check_output("settle_rst_n", {31'd0, div_rst_n},         32'd1);
        check_output("settle_ready", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        @(negedge Ref_CLK);
        check_output("ready_after_settle", {31'd0, cfg_bus.cfg_ready}, 32'd1);

        $display("[TB] ratio 1 enters bypass");
        exp_q.push_back('{ratio: 4'd1, byp: 1'b1, en: 1'b0});
        apply_request(4'd1);
        div_clk_in = 1'b1;
        @(negedge Ref_CLK);
        check_output("byp_pre_en", {31'd0, div_en}, 32'd1);
        div_clk_in = 1'b0;
        @(negedge Ref_CLK);
        check_output("byp_bypass", {31'd0, bypass},    32'd1);
        check_output("byp_en",     {31'd0, div_en},    32'd0);
        check_output("byp_rst_n",  {31'd0, div_rst_n}, 32'd0);
        wait_ready("byp_ready");

        $display("[TB] ratio 5 from bypass restarts directly");
        exp_q.push_back('{ratio: 4'd5, byp: 1'b0, en: 1'b1});
        apply_request(4'd5);
        check_output("direct_rst_n",  {31'd0, div_rst_n}, 32'd0);
        check_output("direct_bypass", {31'd0, bypass},    32'd0);
        check_output("direct_en",     {31'd0, div_en},    32'd1);
        check_output("direct_ratio",  {28'd0, div_ratio}, 32'd5);
        @(negedge Ref_CLK);
        check_output("direct_ready_n2", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        @(negedge Ref_CLK);
        check_output("direct_ready_n3", {31'd0, cfg_bus.cfg_ready}, 32'd1);

        $display("[TB] divider stuck high, ratio 8 via timeout");
        div_clk_in = 1'b1;
        exp_q.push_back('{ratio: 4'd8, byp: 1'b0, en: 1'b1});
        apply_request(4'd8);
        k = 0;
        while (div_rst_n !== 1'b0 && k < 100) begin
            @(negedge Ref_CLK);
            k++;
        end
        check_output("timeout_cycles", k, 32'd32);
        check_output("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        wait_ready("timeout_ready");
        check_output("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
        apply_request(4'd8);
        check_output("timeout_err_clear", {31'd0, timeout_err}, 32'd0);
        check_output("timeout_noop_busy", {31'd0, busy},        32'd0);

        $display("[TB] reset during WAIT_FALL");
        apply_request(4'd3);
        repeat (2) @(negedge Ref_CLK);
        check_output("pre_rst_busy", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        @(negedge Ref_CLK);
        check_reset_values("midrst");
        RST = 1'b0;
        exp_q.push_back('{ratio: 4'd7, byp: 1'b0, en: 1'b1});
        apply_request(4'd7);
        check_output("post_rst_busy", {31'd0, busy}, 32'd1);
        div_clk_in = 1'b0;
        @(negedge Ref_CLK);
        check_output("post_rst_rst_n", {31'd0, div_rst_n}, 32'd0);
        check_output("post_rst_ratio", {28'd0, div_ratio}, 32'd7);
        wait_ready("post_rst_ready");

        check_output("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
